// File: rtl/muldiv_unit_if.sv
// Issue/writeback bundle between the register file, the issue logic and muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  opa;
  logic [WIDTH-1:0]  opb;
  logic [ADDR_W-1:0] rdst_in;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic [ADDR_W-1:0] rdst_out;

  modport master (
    output start, op, opa, opb, rdst_in,
    input  busy, done, result, rdst_out
  );

  modport slave (
    input  start, op, opa, opb, rdst_in,
    output busy, done, result, rdst_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative unsigned 32-bit multiply/divide: shift-add multiply, restoring divide,
// one bit per cycle, single-cycle done pulse for register-file writeback.
//
// state  | meaning
// S_IDLE | waiting for start
// S_RUN  | one multiply/divide iteration per cycle, WIDTH cycles
// S_DONE | result/rdst_out valid, done pulse; start here chains a new op
module muldiv_unit #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6
) (
  input  logic          clk,
  input  logic          rst,
  muldiv_unit_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [WIDTH-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0]    dvsr_q, dvsr_d;
  logic [2*WIDTH-1:0]  prod_q, prod_d;
  logic [WIDTH-1:0]    rem_q, rem_d;
  logic [WIDTH-1:0]    quo_q, quo_d;
  logic [ADDR_W-1:0]   rdst_cap_q, rdst_cap_d;
  logic [WIDTH-1:0]    result_q, result_d;
  logic [ADDR_W-1:0]   rdst_out_q, rdst_out_d;

  logic [WIDTH:0]      sum;
  logic [2*WIDTH-1:0]  prod_step;
  logic [WIDTH:0]      shifted;
  logic                ge;
  logic [WIDTH-1:0]    diff;
  logic [WIDTH-1:0]    rem_step;
  logic [WIDTH-1:0]    quo_step;

  always_comb begin
    sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[WIDTH-1:1]};

    // shifted < 2*divisor, so a successful subtract always fits in WIDTH bits
    shifted  = {rem_q, quo_q[WIDTH-1]};
    ge       = shifted >= {1'b0, dvsr_q};
    diff     = shifted[WIDTH-1:0] - dvsr_q;
    rem_step = ge ? diff : shifted[WIDTH-1:0];
    quo_step = {quo_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    mcand_d    = mcand_q;
    dvsr_d     = dvsr_q;
    prod_d     = prod_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    rdst_cap_d = rdst_cap_q;
    result_d   = result_q;
    rdst_out_d = rdst_out_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          op_d       = bus.op;
          mcand_d    = bus.opa;
          dvsr_d     = bus.opb;
          prod_d     = {{WIDTH{1'b0}}, bus.opb};
          rem_d      = '0;
          quo_d      = bus.opa;
          rdst_cap_d = bus.rdst_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q[1]) begin
          rem_d = rem_step;
          quo_d = quo_step;
        end else begin
          prod_d = prod_step;
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d    = S_DONE;
          rdst_out_d = rdst_cap_q;
          case (op_q)
            2'b00:   result_d = prod_step[WIDTH-1:0];
            2'b01:   result_d = prod_step[2*WIDTH-1:WIDTH];
            2'b10:   result_d = quo_step;
            default: result_d = rem_step;
          endcase
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      mcand_q    <= '0;
      dvsr_q     <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      rdst_cap_q <= '0;
      result_q   <= '0;
      rdst_out_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      mcand_q    <= mcand_d;
      dvsr_q     <= dvsr_d;
      prod_q     <= prod_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      rdst_cap_q <= rdst_cap_d;
      result_q   <= result_d;
      rdst_out_q <= rdst_out_d;
    end
  end

  assign bus.busy     = (state_q == S_RUN);
  assign bus.done     = (state_q == S_DONE);
  assign bus.result   = result_q;
  assign bus.rdst_out = rdst_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle corner
// sequences, and random operations against a plain-arithmetic reference model.
module tb_muldiv_unit;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;
  localparam int LAT    = 33;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  muldiv_unit #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .CNT_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [63:0] p;
    p = {32'b0, a} * {32'b0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Drive a request; caller must be positioned at a negedge.
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.opa     = a;
    bus.opb     = b;
    bus.rdst_in = rd;
  endtask

  // Counts edges from the capture edge until done is seen; optionally pulses a
  // bogus start at edge pulse_at. Returns sitting at the negedge showing done.
  task automatic wait_done(input int pulse_at, output int edges, output int bad_busy);
    edges    = 0;
    bad_busy = 0;
    while (edges < LAT + 8) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      bus.start = 1'b0;
      if (edges == pulse_at) issue(2'b10, 32'd9, 32'd9, 5'd9);
      if (bus.done) break;
      if (!bus.busy) bad_busy++;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int edges, bad_busy;
    @(negedge clk);
    issue(op, a, b, rd);
    wait_done(0, edges, bad_busy);
    check({name, " latency"}, edges, LAT);
    check({name, " busy"}, bad_busy, 0);
    check({name, " result"}, bus.result, exp);
    check({name, " rdst"}, bus.rdst_out, rd);
    @(negedge clk);
    check({name, " done_low"}, bus.done, 1'b0);
  endtask

  initial begin
    int edges, bad_busy, seen_done;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic [4:0]  rrd;

    vecs[0] = '{"mul_7x3",     2'b00, 32'd7,          32'd3,          5'd5,  32'd21};
    vecs[1] = '{"mulhu_max",   2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'hFFFF_FFFE};
    vecs[2] = '{"mul_max",     2'b00, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'h0000_0001};
    vecs[3] = '{"divu_8_3",    2'b10, 32'd8,          32'd3,          5'd3,  32'd2};
    vecs[4] = '{"remu_8_3",    2'b11, 32'd8,          32'd3,          5'd4,  32'd2};
    vecs[5] = '{"divu_3_8",    2'b10, 32'd3,          32'd8,          5'd7,  32'd0};
    vecs[6] = '{"remu_3_8",    2'b11, 32'd3,          32'd8,          5'd8,  32'd3};
    vecs[7] = '{"divu_max_1",  2'b10, 32'hFFFF_FFFF,  32'd1,          5'd31, 32'hFFFF_FFFF};
    vecs[8] = '{"divu_by0",    2'b10, 32'd100,        32'd0,          5'd10, 32'hFFFF_FFFF};
    vecs[9] = '{"remu_by0",    2'b11, 32'd100,        32'd0,          5'd11, 32'd100};

    bus.start = 1'b0; bus.op = '0; bus.opa = '0; bus.opb = '0; bus.rdst_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset result", bus.result, 32'd0);
    check("reset rdst", bus.rdst_out, 5'd0);

    // Start while busy is ignored; start during done chains with no bubble.
    @(negedge clk);
    issue(2'b00, 32'd7, 32'd3, 5'd5);
    wait_done(10, edges, bad_busy);
    check("ign latency", edges, LAT);
    check("ign busy", bad_busy, 0);
    check("ign result", bus.result, 32'd21);
    check("ign rdst", bus.rdst_out, 5'd5);
    issue(2'b00, 32'd2, 32'd4, 5'd6);
    wait_done(0, edges, bad_busy);
    check("b2b latency", edges, LAT);
    check("b2b busy", bad_busy, 0);
    check("b2b result", bus.result, 32'd8);
    check("b2b rdst", bus.rdst_out, 5'd6);
    @(negedge clk);
    check("b2b done_low", bus.done, 1'b0);
    repeat (3) @(negedge clk);
    check("hold result", bus.result, 32'd8);
    check("hold rdst", bus.rdst_out, 5'd6);

    for (int i = 0; i < 10; i++)
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].exp);

    // Reset mid-divide abandons the op with no done.
    @(negedge clk);
    issue(2'b10, 32'd1000, 32'd7, 5'd3);
    repeat (16) @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", bus.busy, 1'b0);
    check("midrst done", bus.done, 1'b0);
    check("midrst result", bus.result, 32'd0);
    check("midrst rdst", bus.rdst_out, 5'd0);
    seen_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) seen_done++;
    end
    check("midrst no_done", seen_done, 0);
    run_op("divu_1000_7", 2'b10, 32'd1000, 32'd7, 5'd4, 32'd142);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'($urandom_range(0, 3));
        1:       rb = 32'($urandom_range(0, 1000));
        default: rb = $urandom;
      endcase
      rrd = 5'($urandom_range(0, 31));
      run_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, rrd, ref_model(rop, ra, rb));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
